data_mem_mmio: RTL
==================

Name: data_mem_mmio

Overview:
- MEM-stage memory block of the pipelined CPU.
- Sits between the EX/MEM register and the MEM/WB register.
- Holds word-addressed data RAM plus memory-mapped peripherals: timer, LEDs, 7-seg digits and a free-running systick.
- Produces the MEM-stage ReadData captured by MEM/WB, and a timer interrupt request to the control unit.

Parameters:
- RAM_DEPTH, 256, data RAM size in 32-bit words; power of two.
- RAM_AW, 8, RAM word-address width; must equal log2(RAM_DEPTH).

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge
- reset  input  1  one clock; reset is asynchronous and active-low
- MemRead  input  1  load in MEM stage
- MemWrite  input  1  store in MEM stage
- Addr  input  32  byte address (ALU result)
- WriteData  input  32  store data
- ReadData  output  32  load data, combinational, same cycle
- leds  output  8  LED register
- digi  output  12  7-seg register: [11:8] digit anodes, [7:0] segments
- irq  output  1  timer interrupt request

Behaviour:
- Address decode:
  - Addr[1:0] ignored.
  - Addr < 0x4000_0000: RAM, word index Addr[RAM_AW+1:2]. Index >= RAM_DEPTH, i.e. any of Addr[29:RAM_AW+2] set: reads return 0, writes are ignored.
  - MMIO map:
    - 0x4000_0000 TH, R/W 32.
    - 0x4000_0004 TL, R/W 32.
    - 0x4000_0008 TCON, R/W bits[2:0]: [0] timer enable, [1] irq enable, [2] irq status. Upper bits read 0.
    - 0x4000_000C LED, R/W 8, zero-extended on read.
    - 0x4000_0010 DIGI, R/W 12, zero-extended on read.
    - 0x4000_0014 SYSTICK, read-only 32; writes ignored.
    - Any other 0x4xxx_xxxx address reads 0; writes are ignored.
- Reads:
  - ReadData is combinational from Addr and current state when MemRead=1; 0 when MemRead=0.
  - Zero read latency: the value is captured by MEM/WB at the next edge.
- Writes:
  - Take effect at the rising edge where MemWrite=1.
  - MemRead and MemWrite both 1: ReadData shows the old value; the write lands at the edge.
- RAM contents are not cleared by reset.
- Reset (reset=0, async) sets TH, TL, TCON, LED, DIGI and SYSTICK to 0. Hence leds=0, digi=0, irq=0.
- Reset asserted mid-store: the store is dropped; RAM may or may not hold the new word. Verification must not check it.
- SYSTICK increments every cycle out of reset and wraps 0xFFFF_FFFF -> 0.
- Timer, each cycle with TCON[0]=1:
  - TL != 0xFFFF_FFFF: TL <= TL+1.
  - TL == 0xFFFF_FFFF (overflow): TL <= TH. If TCON[1]=1, TCON[2] <= 1.
  - TCON[0]=0: TL holds.
- Simultaneous events:
  - CPU write to TL in an increment/reload cycle: CPU write wins.
  - CPU write to TCON in an overflow cycle with TCON[1]=1: bits [1:0] take the written value; bit [2] becomes 1 (hardware set beats software clear, so no interrupt is lost).
  - CPU write to TH in an overflow cycle: the reload uses the old TH.
- irq = TCON[1] & TCON[2], registered state, no combinational path from inputs. Software clears it by writing TCON[2]=0.

Optional Feature:
- Macro MMIO_TIMER_EN.
- Defined: TH/TL/TCON and irq behave as above.
- Undefined: no timer flops; TH/TL/TCON read 0, writes to them are ignored, irq tied 0. The rest of the map is unchanged.

Decomposition:
- Shared package mmio_pkg holds:
  - address constants: ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_DIGI, ADDR_SYSTICK, MMIO_BASE.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IS=2.
  - RAM default depth.
- One sub-module, mmio_timer:
  - owns TH/TL/TCON and irq.
  - inputs: clk, reset, write strobes and data.
  - outputs: register values for read-back.
  - instantiated only under MMIO_TIMER_EN.

Test Plan:
- Reset then idle 5 cycles -> leds=0, digi=0, irq=0. Read SYSTICK -> 5 (±1 for the sample edge; exact value per bench timing).
- Store 0xDEADBEEF at 0x0000_0010, then load 0x0000_0013 -> ReadData=0xDEADBEEF. Load 0x0000_0400 (RAM_DEPTH=256) -> 0.
- Write LED=0x1A5, DIGI=0xF3C -> leds=0xA5, digi=0xF3C. Read LED -> 0x0000_00A5.
- TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3:
  - 2 cycles later TL=0xFFFF_FFFC, TCON=7, irq=1.
  - Write TCON=3 -> irq=0.
  - 4 cycles later irq=1 again.
- Write TCON=3 (clear attempt) in the exact overflow cycle -> TCON reads 7, irq stays 1.
- Build without MMIO_TIMER_EN:
  - write TCON=3, TL=0xFFFF_FFFF, run 10 cycles -> TL/TCON read 0, irq=0.
  - RAM/LED/SYSTICK still pass the tests above.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared address map, TCON bit layout and read-select encoding for data_mem_mmio.
package mmio_pkg;

  localparam int RAM_DEPTH_DEFAULT = 256;

  localparam logic [31:0] MMIO_BASE    = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  localparam int TCON_W  = 3;
  localparam int LED_W   = 8;
  localparam int DIGI_W  = 12;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGI,
    SEL_SYSTICK
  } sel_e;

  // Word-aligned address to peripheral select; anything unmapped gives SEL_NONE.
  function automatic sel_e mmio_sel(input logic [31:0] word_addr);
    sel_e s;
    case (word_addr)
      ADDR_TH:      s = SEL_TH;
      ADDR_TL:      s = SEL_TL;
      ADDR_TCON:    s = SEL_TCON;
      ADDR_LED:     s = SEL_LED;
      ADDR_DIGI:    s = SEL_DIGI;
      ADDR_SYSTICK: s = SEL_SYSTICK;
      default:      s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Reloading up-timer with TH/TL/TCON registers and a level interrupt request.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_th,
  input  logic              we_tl,
  input  logic              we_tcon,
  input  logic [31:0]       wdata,
  output logic [31:0]       th,
  output logic [31:0]       tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irq
);

  logic ovf;

  assign ovf = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (we_th) th <= wdata;

      // A CPU write to TL overrides both the increment and the reload.
      if (we_tl) tl <= wdata;
      else if (tcon[TCON_EN]) tl <= ovf ? th : tl + 32'd1;

      if (we_tcon) begin
        tcon[TCON_EN] <= wdata[TCON_EN];
        tcon[TCON_IE] <= wdata[TCON_IE];
      end

      // Hardware set beats a software clear so an overflow is never lost.
      if (ovf && tcon[TCON_IE]) tcon[TCON_IS] <= 1'b1;
      else if (we_tcon) tcon[TCON_IS] <= wdata[TCON_IS];
    end
  end

  assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/data_mem_mmio.sv
// MEM-stage data RAM plus memory-mapped LED, 7-seg, systick and (with MMIO_TIMER_EN) timer.
// Without MMIO_TIMER_EN the timer registers read 0, ignore writes and irq is tied low.
module data_mem_mmio
  import mmio_pkg::*;
#(
  parameter int RAM_DEPTH = RAM_DEPTH_DEFAULT,
  parameter int RAM_AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic [LED_W-1:0]  leds,
  output logic [DIGI_W-1:0] digi,
  output logic              irq
);

  logic [31:0]       word_addr;
  logic              addr_lsb_unused;
  logic              ram_region;
  logic              ram_in_range;
  logic [RAM_AW-1:0] ram_idx;
  sel_e              sel;

  logic [31:0]       ram [RAM_DEPTH];
  logic [31:0]       ram_rdata;
  logic [31:0]       systick;

  logic [31:0]       th_q;
  logic [31:0]       tl_q;
  logic [TCON_W-1:0] tcon_q;

  assign word_addr       = {Addr[31:2], 2'b00};
  assign addr_lsb_unused = ^Addr[1:0];
  assign ram_region      = (Addr[31:30] == 2'b00);
  assign ram_in_range    = (Addr[29:RAM_AW+2] == '0);
  assign ram_idx         = Addr[RAM_AW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (ram_region) begin
      if (ram_in_range) sel = SEL_RAM;
    end else begin
      sel = mmio_sel(word_addr);
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (MemWrite && (sel == SEL_RAM)) ram[ram_idx] <= WriteData;
  end

  assign ram_rdata = ram[ram_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds    <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (MemWrite && (sel == SEL_LED))  leds <= WriteData[LED_W-1:0];
      if (MemWrite && (sel == SEL_DIGI)) digi <= WriteData[DIGI_W-1:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic we_th;
  logic we_tl;
  logic we_tcon;

  assign we_th   = MemWrite && (sel == SEL_TH);
  assign we_tl   = MemWrite && (sel == SEL_TL);
  assign we_tcon = MemWrite && (sel == SEL_TCON);

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we_th   (we_th),
    .we_tl   (we_tl),
    .we_tcon (we_tcon),
    .wdata   (WriteData),
    .th      (th_q),
    .tl      (tl_q),
    .tcon    (tcon_q),
    .irq     (irq)
  );
`else
  assign th_q   = '0;
  assign tl_q   = '0;
  assign tcon_q = '0;
  assign irq    = 1'b0;
`endif

  // Combinational read; with a simultaneous store this shows the pre-edge value.
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      case (sel)
        SEL_RAM:     ReadData = ram_rdata;
        SEL_TH:      ReadData = th_q;
        SEL_TL:      ReadData = tl_q;
        SEL_TCON:    ReadData = {{(32-TCON_W){1'b0}}, tcon_q};
        SEL_LED:     ReadData = {{(32-LED_W){1'b0}}, leds};
        SEL_DIGI:    ReadData = {{(32-DIGI_W){1'b0}}, digi};
        SEL_SYSTICK: ReadData = systick;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule
